controle_tiro_nave: RTL and testbench

//   Schedules the player's single shot. It samples the fire button, launches the shot from the ship's

---
 rtl/controle_tiro_nave.sv | 150 +++++++++++++++
 tb/tb_controle_tiro_nave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_tiro_nave.sv
// Player shot controller: samples the fire button, launches a single shot
// from the ship's nose, steps it upward at a fixed rate, ends the flight on a
// hit, on player death or at the screen top, then holds a cooldown before the
// next shot may be fired.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OCIOSO  | no shot; waiting for a fresh button press while alive
// VOO     | shot in flight; position steps up every STEP_DELAY clocks
// RECARGA | shot ended; cooldown of COOLDOWN clocks, presses discarded
module controle_tiro_nave #(
    parameter int unsigned STEP_DELAY = 250000,
    parameter int unsigned STEP_PX    = 4,
    parameter int unsigned Y_START    = 488,
    parameter int unsigned Y_TOP      = 40,
    parameter int unsigned NOSE_OFF   = 10,
    parameter int unsigned COOLDOWN   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_C,
    input  logic [10:0] posX_Nave,
    input  logic        vivo_jogador,
    input  logic        acerto,
    output logic [10:0] posX_Municao,
    output logic [10:0] posY_Municao,
    output logic        tiro_ativo,
    output logic        tiro_fim,
    output logic        fim_acerto
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        VOO     = 2'd1,
        RECARGA = 2'd2
    } estado_t;

    localparam logic [25:0] STEP_LAST = 26'(STEP_DELAY - 1);
    localparam logic [25:0] COOL_LAST = 26'(COOLDOWN - 1);
    localparam logic [10:0] STEP_PX_W = 11'(STEP_PX);
    localparam logic [10:0] Y_START_W = 11'(Y_START);
    localparam logic [10:0] NOSE_W    = 11'(NOSE_OFF);
    // A step from below this line would cross Y_TOP, so the flight ends instead.
    localparam logic [10:0] Y_LIMIT   = 11'(Y_TOP + STEP_PX);

    estado_t     state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [10:0] posx_q, posx_d;
    logic [10:0] posy_q, posy_d;
    logic        tiro_fim_q, tiro_fim_d;
    logic        fim_acerto_q, fim_acerto_d;

    logic sync1_q, sync2_q, prev_q;
    logic press;
    logic step;
    logic end_top;

    // Two-flop synchronizer plus edge register; idle level is 1 (button released).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_C;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only a 1->0 transition counts, so a button held through RECARGA never fires.
    assign press   = prev_q & ~sync2_q;
    assign step    = (cnt_q == STEP_LAST);
    assign end_top = step && (posy_q < Y_LIMIT);

    // State, counter, position and end-of-flight registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= OCIOSO;
            cnt_q        <= '0;
            posx_q       <= '0;
            posy_q       <= '0;
            tiro_fim_q   <= 1'b0;
            fim_acerto_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            posx_q       <= posx_d;
            posy_q       <= posy_d;
            tiro_fim_q   <= tiro_fim_d;
            fim_acerto_q <= fim_acerto_d;
        end
    end

    // Next-state logic: launch, stepping, end-of-flight priority and cooldown.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        posx_d       = posx_q;
        posy_d       = posy_q;
        tiro_fim_d   = 1'b0;
        fim_acerto_d = fim_acerto_q;

        unique case (state_q)
            OCIOSO: begin
                cnt_d = '0;
                if (press && vivo_jogador) begin
                    state_d = VOO;
                    posx_d  = posX_Nave + NOSE_W;
                    posy_d  = Y_START_W;
                end
            end
            VOO: begin
                cnt_d = step ? '0 : cnt_q + 26'd1;
                // Hit beats abort, abort beats reaching the top.
                if (acerto || !vivo_jogador || end_top) begin
                    state_d      = RECARGA;
                    cnt_d        = '0;
                    posx_d       = '0;
                    posy_d       = '0;
                    tiro_fim_d   = 1'b1;
                    fim_acerto_d = acerto;
                end else if (step) begin
                    posy_d = posy_q - STEP_PX_W;
                end
            end
            RECARGA: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = OCIOSO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = OCIOSO;
                cnt_d   = '0;
                posx_d  = '0;
                posy_d  = '0;
            end
        endcase
    end

    assign posX_Municao = posx_q;
    assign posY_Municao = posy_q;
    assign tiro_ativo   = (state_q == VOO);
    assign tiro_fim     = tiro_fim_q;
    assign fim_acerto   = fim_acerto_q;

endmodule

// File: tb/tb_controle_tiro_nave.sv
// Directed bench for controle_tiro_nave with short timing parameters.
module tb_controle_tiro_nave;

    logic        clk;
    logic        reset;
    logic        btn_C;
    logic [10:0] posX_Nave;
    logic        vivo_jogador;
    logic        acerto;
    logic [10:0] posX_Municao;
    logic [10:0] posY_Municao;
    logic        tiro_ativo;
    logic        tiro_fim;
    logic        fim_acerto;

    int checks   = 0;
    int failures = 0;

    controle_tiro_nave #(
        .STEP_DELAY(4),
        .STEP_PX   (4),
        .Y_START   (100),
        .Y_TOP     (40),
        .NOSE_OFF  (10),
        .COOLDOWN  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_C       (btn_C),
        .posX_Nave   (posX_Nave),
        .vivo_jogador(vivo_jogador),
        .acerto      (acerto),
        .posX_Municao(posX_Municao),
        .posY_Municao(posY_Municao),
        .tiro_ativo  (tiro_ativo),
        .tiro_fim    (tiro_fim),
        .fim_acerto  (fim_acerto)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presses the button now and expects launch on the third edge.
    task automatic launch(input logic [10:0] x, input logic [10:0] exp_x);
        int n;
        n = 0;
        posX_Nave = x;
        btn_C = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (tiro_ativo === 1'b1) begin
                n = i;
                break;
            end
        end
        btn_C = 1'b1;
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL launch_latency got=%0d exp=3", n);
        end
        checks++;
        if (posX_Municao !== exp_x) begin
            failures++;
            $display("FAIL launch_posX got=%0d exp=%0d", posX_Municao, exp_x);
        end
        checks++;
        if (posY_Municao !== 11'd100) begin
            failures++;
            $display("FAIL launch_posY got=%0d exp=100", posY_Municao);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_C = 1'b1;
        vivo_jogador = 1'b1;
        acerto = 1'b0;
        posX_Nave = 11'd0;
        #12;
        checks++;
        if ({posX_Municao, posY_Municao, tiro_ativo, tiro_fim, fim_acerto} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {posX_Municao, posY_Municao, tiro_ativo, tiro_fim, fim_acerto});
        end
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_acerto_idle();
        acerto = 1'b1;
        tick();
        acerto = 1'b0;
        checks++;
        if (tiro_fim !== 1'b0 || tiro_ativo !== 1'b0) begin
            failures++;
            $display("FAIL acerto_idle fim=%b ativo=%b exp=0,0", tiro_fim, tiro_ativo);
        end
        tick();
    endtask

    task automatic test_launch();
        launch(11'd445, 11'd455);
    endtask

    // Continues the flight from test_launch up to the top, then probes cooldown.
    task automatic test_flight_top();
        bit fired;
        for (int k = 1; k <= 15; k++) begin
            repeat (3) tick();
            if (k == 1) begin
                checks++;
                if (posY_Municao !== 11'd100) begin
                    failures++;
                    $display("FAIL pre_step_posY got=%0d exp=100", posY_Municao);
                end
            end
            tick();
            if (k == 5) btn_C = 1'b0;
            if (k == 8) btn_C = 1'b1;
            checks++;
            if (posY_Municao !== 11'(100 - 4 * k) || tiro_ativo !== 1'b1 || posX_Municao !== 11'd455) begin
                failures++;
                $display("FAIL step_%0d posY=%0d ativo=%b posX=%0d exp=%0d,1,455",
                         k, posY_Municao, tiro_ativo, posX_Municao, 100 - 4 * k);
            end
        end
        repeat (4) tick();
        checks++;
        if (tiro_fim !== 1'b1 || fim_acerto !== 1'b0 || tiro_ativo !== 1'b0 ||
            posX_Municao !== 11'd0 || posY_Municao !== 11'd0) begin
            failures++;
            $display("FAIL top_end fim=%b acerto=%b ativo=%b x=%0d y=%0d exp=1,0,0,0,0",
                     tiro_fim, fim_acerto, tiro_ativo, posX_Municao, posY_Municao);
        end
        tick();
        checks++;
        if (tiro_fim !== 1'b0) begin
            failures++;
            $display("FAIL top_fim_pulse got=%b exp=0", tiro_fim);
        end
        // Press reaches the FSM in the last cooldown cycle and stays held into OCIOSO.
        repeat (4) tick();
        btn_C = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tiro_ativo === 1'b1) fired = 1'b1;
        end
        checks++;
        if (fired !== 1'b0) begin
            failures++;
            $display("FAIL held_press_fired got=%b exp=0", fired);
        end
        btn_C = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_hit();
        launch(11'd100, 11'd110);
        repeat (28) tick();
        checks++;
        if (posY_Municao !== 11'd72) begin
            failures++;
            $display("FAIL hit_posY got=%0d exp=72", posY_Municao);
        end
        acerto = 1'b1;
        tick();
        acerto = 1'b0;
        checks++;
        if (tiro_fim !== 1'b1 || fim_acerto !== 1'b1 || tiro_ativo !== 1'b0 ||
            posX_Municao !== 11'd0 || posY_Municao !== 11'd0) begin
            failures++;
            $display("FAIL hit_end fim=%b acerto=%b ativo=%b x=%0d y=%0d exp=1,1,0,0,0",
                     tiro_fim, fim_acerto, tiro_ativo, posX_Municao, posY_Municao);
        end
        tick();
        checks++;
        if (tiro_fim !== 1'b0 || fim_acerto !== 1'b1) begin
            failures++;
            $display("FAIL hit_hold fim=%b acerto=%b exp=0,1", tiro_fim, fim_acerto);
        end
        // Press reaches the FSM in the first OCIOSO cycle: must launch.
        repeat (5) tick();
        launch(11'd300, 11'd310);
    endtask

    // Continues the flight from test_hit; hit lands on the same cycle as the top step.
    task automatic test_hit_at_top();
        repeat (63) tick();
        checks++;
        if (posY_Municao !== 11'd40 || tiro_ativo !== 1'b1) begin
            failures++;
            $display("FAIL top_hit_pre posY=%0d ativo=%b exp=40,1", posY_Municao, tiro_ativo);
        end
        acerto = 1'b1;
        tick();
        acerto = 1'b0;
        checks++;
        if (tiro_fim !== 1'b1 || fim_acerto !== 1'b1) begin
            failures++;
            $display("FAIL top_hit_end fim=%b acerto=%b exp=1,1", tiro_fim, fim_acerto);
        end
        repeat (10) tick();
    endtask

    task automatic test_abort_inhibit();
        bit fired;
        launch(11'd0, 11'd10);
        repeat (10) tick();
        vivo_jogador = 1'b0;
        tick();
        checks++;
        if (tiro_fim !== 1'b1 || fim_acerto !== 1'b0 || tiro_ativo !== 1'b0 || posY_Municao !== 11'd0) begin
            failures++;
            $display("FAIL abort_end fim=%b acerto=%b ativo=%b y=%0d exp=1,0,0,0",
                     tiro_fim, fim_acerto, tiro_ativo, posY_Municao);
        end
        repeat (10) tick();
        btn_C = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tiro_ativo === 1'b1) fired = 1'b1;
        end
        checks++;
        if (fired !== 1'b0) begin
            failures++;
            $display("FAIL dead_press_fired got=%b exp=0", fired);
        end
        btn_C = 1'b1;
        vivo_jogador = 1'b1;
        repeat (3) tick();
        launch(11'd2040, 11'd2);
    endtask

    // Continues the wrapped-X flight; reset lands between clock edges.
    task automatic test_async_reset();
        repeat (5) tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({posX_Municao, posY_Municao, tiro_ativo, tiro_fim, fim_acerto} !== 25'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0",
                     {posX_Municao, posY_Municao, tiro_ativo, tiro_fim, fim_acerto});
        end
        #2;
        reset = 1'b0;
        repeat (2) tick();
        launch(11'd445, 11'd455);
        repeat (4) tick();
        checks++;
        if (posY_Municao !== 11'd96) begin
            failures++;
            $display("FAIL post_reset_step got=%0d exp=96", posY_Municao);
        end
    endtask

    initial begin
        test_reset();
        test_acerto_idle();
        test_launch();
        test_flight_top();
        test_hit();
        test_hit_at_top();
        test_abort_inhibit();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
